// File: rtl/mmu_req_gen.sv
// Client-side traffic generator for the MMU FIFOs: issues allocations, buffers the
// granted pages, frees them again and tallies failed responses over one run.

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 4
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 12
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 3
`endif

module mmu_req_gen #(
  parameter int MAX_HELD  = 16,
  parameter int HELD_PTR  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [CNT_WIDTH-1:0]            cfg_op_count,
  input  logic [`REQ_SIZE_TYPE_WIDTH-1:0] cfg_page_count,
  output logic                            alloc_req_push,
  output logic [`REQ_ID_WIDTH-1:0]        alloc_req_id,
  output logic [`REQ_SIZE_TYPE_WIDTH-1:0] alloc_req_page_count,
  input  logic                            alloc_req_fifo_full,
  output logic                            free_req_push,
  output logic [`REQ_ID_WIDTH-1:0]        free_req_id,
  output logic [`ALL_PAGE_IDX_WIDTH-1:0]  free_req_page_idx,
  output logic [`REQ_SIZE_TYPE_WIDTH-1:0] free_req_page_count,
  input  logic                            free_req_fifo_full,
  output logic                            alloc_rsp_pop,
  input  logic [`REQ_ID_WIDTH-1:0]        alloc_rsp_id,
  input  logic [`ALL_PAGE_IDX_WIDTH-1:0]  alloc_rsp_page_idx,
  input  logic                            alloc_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0]   alloc_rsp_fail_reason,
  input  logic                            alloc_rsp_fifo_empty,
  output logic                            free_rsp_pop,
  input  logic [`REQ_ID_WIDTH-1:0]        free_rsp_id,
  input  logic                            free_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0]   free_rsp_fail_reason,
  input  logic                            free_rsp_fifo_empty,
  output logic                            busy,
  output logic                            done,
  output logic [CNT_WIDTH-1:0]            alloc_fail_cnt,
  output logic [CNT_WIDTH-1:0]            free_fail_cnt
);

  localparam int ID_W   = `REQ_ID_WIDTH;
  localparam int PC_W   = `REQ_SIZE_TYPE_WIDTH;
  localparam int IDX_W  = `ALL_PAGE_IDX_WIDTH;
  localparam int HELD_W = HELD_PTR + 1;

  localparam logic [HELD_W-1:0] HELD_LIMIT = HELD_W'(MAX_HELD);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [PC_W-1:0]      page_count_q, page_count_d;
  logic [ID_W-1:0]      next_id_q, next_id_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] alloc_rcvd_q, alloc_rcvd_d;
  logic [CNT_WIDTH-1:0] free_pushed_q, free_pushed_d;
  logic [CNT_WIDTH-1:0] free_rcvd_q, free_rcvd_d;
  logic [CNT_WIDTH-1:0] alloc_fail_cnt_q, alloc_fail_cnt_d;
  logic [CNT_WIDTH-1:0] free_fail_cnt_q, free_fail_cnt_d;
  logic [HELD_W-1:0]    held_q, held_d;
  logic                 alloc_pend_q, alloc_pend_d;
  logic                 free_pend_q, free_pend_d;
  logic [HELD_PTR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [HELD_PTR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [HELD_W-1:0]    buf_cnt_q, buf_cnt_d;

  logic [ID_W-1:0]  buf_id_q  [MAX_HELD];
  logic [IDX_W-1:0] buf_idx_q [MAX_HELD];

  logic in_run;
  logic buf_empty;
  logic buf_wr;
  logic alloc_bad;
  logic run_end;
  logic unused_rsp_fields;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign unused_rsp_fields = ^{free_rsp_id, alloc_rsp_fail_reason, free_rsp_fail_reason};

  assign in_run    = (state_q == ST_RUN);
  assign buf_empty = (buf_cnt_q == '0);
  assign buf_wr    = alloc_pend_q && !alloc_rsp_fail;
  assign alloc_bad = alloc_pend_q && alloc_rsp_fail;

  // held counts pages pushed but not yet freed or refused, so it bounds the buffer too
  assign alloc_req_push = in_run && (issued_q < n_q) && !alloc_req_fifo_full
                          && (held_q < HELD_LIMIT);
  assign alloc_rsp_pop  = in_run && !alloc_rsp_fifo_empty;
  assign free_req_push  = in_run && !buf_empty && !free_req_fifo_full;
  assign free_rsp_pop   = in_run && !free_rsp_fifo_empty;

  assign alloc_req_id         = alloc_req_push ? next_id_q : '0;
  assign alloc_req_page_count = alloc_req_push ? page_count_q : '0;
  assign free_req_id          = free_req_push ? buf_id_q[rd_ptr_q] : '0;
  assign free_req_page_idx    = free_req_push ? buf_idx_q[rd_ptr_q] : '0;
  assign free_req_page_count  = free_req_push ? page_count_q : '0;

  assign busy           = in_run;
  assign done           = (state_q == ST_DONE);
  assign alloc_fail_cnt = alloc_fail_cnt_q;
  assign free_fail_cnt  = free_fail_cnt_q;

  assign run_end = (issued_q == n_q) && (alloc_rcvd_q == n_q)
                   && (free_pushed_q == free_rcvd_q) && (held_q == '0)
                   && !alloc_pend_q && !free_pend_q;

  always_comb begin
    state_d          = state_q;
    n_d              = n_q;
    page_count_d     = page_count_q;
    next_id_d        = next_id_q;
    issued_d         = issued_q;
    alloc_rcvd_d     = alloc_rcvd_q;
    free_pushed_d    = free_pushed_q;
    free_rcvd_d      = free_rcvd_q;
    alloc_fail_cnt_d = alloc_fail_cnt_q;
    free_fail_cnt_d  = free_fail_cnt_q;
    alloc_pend_d     = alloc_rsp_pop;
    free_pend_d      = free_rsp_pop;

    if (alloc_req_push) begin
      next_id_d = next_id_q + ID_W'(1);
      issued_d  = issued_q + CNT_WIDTH'(1);
    end
    if (alloc_pend_q) begin
      alloc_rcvd_d = alloc_rcvd_q + CNT_WIDTH'(1);
      if (alloc_rsp_fail) alloc_fail_cnt_d = sat_inc(alloc_fail_cnt_q);
    end
    if (free_req_push) free_pushed_d = free_pushed_q + CNT_WIDTH'(1);
    if (free_pend_q) begin
      free_rcvd_d = free_rcvd_q + CNT_WIDTH'(1);
      if (free_rsp_fail) free_fail_cnt_d = sat_inc(free_fail_cnt_q);
    end

    held_d    = held_q + HELD_W'(alloc_req_push) - HELD_W'(alloc_bad) - HELD_W'(free_req_push);
    wr_ptr_d  = wr_ptr_q + HELD_PTR'(buf_wr);
    rd_ptr_d  = rd_ptr_q + HELD_PTR'(free_req_push);
    buf_cnt_d = buf_cnt_q + HELD_W'(buf_wr) - HELD_W'(free_req_push);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d              = cfg_op_count;
          page_count_d     = cfg_page_count;
          next_id_d        = '0;
          issued_d         = '0;
          alloc_rcvd_d     = '0;
          free_pushed_d    = '0;
          free_rcvd_d      = '0;
          alloc_fail_cnt_d = '0;
          free_fail_cnt_d  = '0;
          held_d           = '0;
          wr_ptr_d         = '0;
          rd_ptr_d         = '0;
          buf_cnt_d        = '0;
          state_d          = (cfg_op_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN:  if (run_end) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      n_q              <= '0;
      page_count_q     <= '0;
      next_id_q        <= '0;
      issued_q         <= '0;
      alloc_rcvd_q     <= '0;
      free_pushed_q    <= '0;
      free_rcvd_q      <= '0;
      alloc_fail_cnt_q <= '0;
      free_fail_cnt_q  <= '0;
      held_q           <= '0;
      alloc_pend_q     <= 1'b0;
      free_pend_q      <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      buf_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      n_q              <= n_d;
      page_count_q     <= page_count_d;
      next_id_q        <= next_id_d;
      issued_q         <= issued_d;
      alloc_rcvd_q     <= alloc_rcvd_d;
      free_pushed_q    <= free_pushed_d;
      free_rcvd_q      <= free_rcvd_d;
      alloc_fail_cnt_q <= alloc_fail_cnt_d;
      free_fail_cnt_q  <= free_fail_cnt_d;
      held_q           <= held_d;
      alloc_pend_q     <= alloc_pend_d;
      free_pend_q      <= free_pend_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      buf_cnt_q        <= buf_cnt_d;
    end
  end

  // Storage only; validity is tracked by the pointers and count above
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_id_q[wr_ptr_q]  <= alloc_rsp_id;
      buf_idx_q[wr_ptr_q] <= alloc_rsp_page_idx;
    end
  end

endmodule

// File: tb/tb_mmu_req_gen.sv
// Self-checking bench for mmu_req_gen: emulates the four MMU FIFOs and keeps a
// queue-based model of the run that every cycle's outputs are compared against.

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 4
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 12
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 3
`endif

module tb_mmu_req_gen;
   localparam int CNT_W    = 16;
   localparam int ID_W     = `REQ_ID_WIDTH;
   localparam int PC_W     = `REQ_SIZE_TYPE_WIDTH;
   localparam int IDX_W    = `ALL_PAGE_IDX_WIDTH;
   localparam int FR_W     = `FAIL_REASON_WIDTH;
   localparam int MAX_HELD = 16;
   localparam int FIFO_DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic [CNT_W-1:0] cfg_op_count;
   logic [PC_W-1:0] cfg_page_count;
   logic alloc_req_push;
   logic [ID_W-1:0] alloc_req_id;
   logic [PC_W-1:0] alloc_req_page_count;
   logic alloc_req_fifo_full;
   logic free_req_push;
   logic [ID_W-1:0] free_req_id;
   logic [IDX_W-1:0] free_req_page_idx;
   logic [PC_W-1:0] free_req_page_count;
   logic free_req_fifo_full;
   logic alloc_rsp_pop;
   logic [ID_W-1:0] alloc_rsp_id;
   logic [IDX_W-1:0] alloc_rsp_page_idx;
   logic alloc_rsp_fail;
   logic [FR_W-1:0] alloc_rsp_fail_reason;
   logic alloc_rsp_fifo_empty;
   logic free_rsp_pop;
   logic [ID_W-1:0] free_rsp_id;
   logic free_rsp_fail;
   logic [FR_W-1:0] free_rsp_fail_reason;
   logic free_rsp_fifo_empty;
   logic busy;
   logic done;
   logic [CNT_W-1:0] alloc_fail_cnt;
   logic [CNT_W-1:0] free_fail_cnt;

   mmu_req_gen #(.MAX_HELD(MAX_HELD), .HELD_PTR(4), .CNT_WIDTH(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_op_count(cfg_op_count), .cfg_page_count(cfg_page_count),
      .alloc_req_push(alloc_req_push), .alloc_req_id(alloc_req_id),
      .alloc_req_page_count(alloc_req_page_count), .alloc_req_fifo_full(alloc_req_fifo_full),
      .free_req_push(free_req_push), .free_req_id(free_req_id),
      .free_req_page_idx(free_req_page_idx), .free_req_page_count(free_req_page_count),
      .free_req_fifo_full(free_req_fifo_full),
      .alloc_rsp_pop(alloc_rsp_pop), .alloc_rsp_id(alloc_rsp_id),
      .alloc_rsp_page_idx(alloc_rsp_page_idx), .alloc_rsp_fail(alloc_rsp_fail),
      .alloc_rsp_fail_reason(alloc_rsp_fail_reason), .alloc_rsp_fifo_empty(alloc_rsp_fifo_empty),
      .free_rsp_pop(free_rsp_pop), .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail),
      .free_rsp_fail_reason(free_rsp_fail_reason), .free_rsp_fifo_empty(free_rsp_fifo_empty),
      .busy(busy), .done(done),
      .alloc_fail_cnt(alloc_fail_cnt), .free_fail_cnt(free_fail_cnt)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int idx;
      bit fail;
   } rspT;

   // MMU emulation: request FIFOs, response FIFOs and the data staged for the cycle after a pop
   int  areqQ[$];
   rspT arspQ[$];
   int  freqQ[$];
   rspT frspQ[$];
   rspT arData;
   rspT frData;
   bit  arValid;
   bit  frValid;
   int  grantSeq;
   int  rspSeq;
   int  failAt;
   bit  forceAllocFull;
   bit  stallAllocRsp;

   // Run model: counts of what has happened, plus the pages granted and not yet freed
   bit  mRunning;
   bit  mDone;
   int  mN;
   int  mPc;
   int  mIssued;
   int  mAllocRcvd;
   int  mFreePushed;
   int  mFreeRcvd;
   int  mHeld;
   int  mNextId;
   int  mAllocFail;
   int  mFreeFail;
   bit  mAllocPend;
   bit  mFreePend;
   rspT grantQ[$];

   // What the DUT actually did, for the hand-computed end-of-test checks
   int  allocIdLog[$];
   rspT freeLog[$];
   int  doneCount;

   int  passCount;
   int  checkCount;

   // One comparison: counts it, and reports it when the values differ
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                    name, actual, actual, expected, expected);
   endtask

   // Everything the model believes returns to its post-reset picture
   task automatic resetModel();
      mRunning = 0; mDone = 0; mN = 0; mPc = 0;
      mIssued = 0; mAllocRcvd = 0; mFreePushed = 0; mFreeRcvd = 0;
      mHeld = 0; mNextId = 0; mAllocFail = 0; mFreeFail = 0;
      mAllocPend = 0; mFreePend = 0;
      grantQ.delete();
   endtask

   // Empties the emulated FIFOs and restores the default MMU behaviour
   task automatic clearEnv();
      areqQ.delete(); arspQ.delete(); freqQ.delete(); frspQ.delete();
      arValid = 0; frValid = 0;
      grantSeq = 0; rspSeq = 0; failAt = -1;
      forceAllocFull = 0; stallAllocRsp = 0;
   endtask

   // One clock cycle: drive at the falling edge, compare #1 later, then advance MMU and model
   task automatic applyStimulus(input bit startIn, input int n, input int pc);
      bit  aFull, fFull, aEmpty, fEmpty;
      bit  expAPush, expAPop, expFPush, expFPop, endNow;
      bit  curArValid, curFrValid;
      rspT curAr, curFr, r;
      @(negedge clk);
      curAr = arData; curArValid = arValid;
      curFr = frData; curFrValid = frValid;
      if (curArValid) begin
         alloc_rsp_id = ID_W'(curAr.id);
         alloc_rsp_page_idx = IDX_W'(curAr.idx);
         alloc_rsp_fail = curAr.fail;
         alloc_rsp_fail_reason = curAr.fail ? FR_W'(2) : '0;
      end else begin
         alloc_rsp_id = '1; alloc_rsp_page_idx = '1; alloc_rsp_fail = 1'b1; alloc_rsp_fail_reason = '1;
      end
      if (curFrValid) begin
         free_rsp_id = ID_W'(curFr.id);
         free_rsp_fail = curFr.fail;
         free_rsp_fail_reason = '0;
      end else begin
         free_rsp_id = '1; free_rsp_fail = 1'b1; free_rsp_fail_reason = '1;
      end
      if (areqQ.size() > 0) begin
         r.id = areqQ.pop_front();
         r.fail = (rspSeq == failAt);
         r.idx = r.fail ? 'hFFF : grantSeq * 8;
         if (!r.fail) grantSeq++;
         rspSeq++;
         arspQ.push_back(r);
      end
      if (freqQ.size() > 0) begin
         r.id = freqQ.pop_front();
         r.idx = 0;
         r.fail = 0;
         frspQ.push_back(r);
      end
      aFull  = forceAllocFull || (areqQ.size() >= FIFO_DEPTH);
      fFull  = (freqQ.size() >= FIFO_DEPTH);
      aEmpty = stallAllocRsp || (arspQ.size() == 0);
      fEmpty = (frspQ.size() == 0);
      alloc_req_fifo_full  = aFull;
      free_req_fifo_full   = fFull;
      alloc_rsp_fifo_empty = aEmpty;
      free_rsp_fifo_empty  = fEmpty;
      start          = startIn;
      cfg_op_count   = CNT_W'(n);
      cfg_page_count = PC_W'(pc);
      #1;

      expAPush = mRunning && (mIssued < mN) && !aFull && (mHeld < MAX_HELD);
      expAPop  = mRunning && !aEmpty;
      expFPush = mRunning && (grantQ.size() > 0) && !fFull;
      expFPop  = mRunning && !fEmpty;
      endNow   = mRunning && (mIssued == mN) && (mAllocRcvd == mN) && (mFreePushed == mFreeRcvd)
                 && (mHeld == 0) && !mAllocPend && !mFreePend;

      checkOutput("busy", busy, mRunning);
      checkOutput("done", done, mDone);
      checkOutput("alloc_req_push", alloc_req_push, expAPush);
      checkOutput("alloc_rsp_pop", alloc_rsp_pop, expAPop);
      checkOutput("free_req_push", free_req_push, expFPush);
      checkOutput("free_rsp_pop", free_rsp_pop, expFPop);
      checkOutput("alloc_fail_cnt", alloc_fail_cnt, mAllocFail);
      checkOutput("free_fail_cnt", free_fail_cnt, mFreeFail);
      if (expAPush) begin
         checkOutput("alloc_req_id", alloc_req_id, mNextId);
         checkOutput("alloc_req_page_count", alloc_req_page_count, mPc);
      end
      if (expFPush) begin
         checkOutput("free_req_id", free_req_id, grantQ[0].id);
         checkOutput("free_req_page_idx", free_req_page_idx, grantQ[0].idx);
         checkOutput("free_req_page_count", free_req_page_count, mPc);
      end

      if (alloc_req_push) begin
         areqQ.push_back(int'(alloc_req_id));
         allocIdLog.push_back(int'(alloc_req_id));
      end
      if (free_req_push) begin
         freqQ.push_back(int'(free_req_id));
         r.id = int'(free_req_id);
         r.idx = int'(free_req_page_idx);
         r.fail = 0;
         freeLog.push_back(r);
      end
      arValid = 0;
      if (alloc_rsp_pop && !aEmpty) begin
         arData = arspQ.pop_front();
         arValid = 1;
      end
      frValid = 0;
      if (free_rsp_pop && !fEmpty) begin
         frData = frspQ.pop_front();
         frValid = 1;
      end
      if (done) doneCount++;

      if (expFPush) begin
         grantQ.delete(0);
         mFreePushed++;
         mHeld--;
      end
      if (mAllocPend) begin
         mAllocRcvd++;
         if (!curArValid || curAr.fail) begin
            if (mAllocFail < 65535) mAllocFail++;
            mHeld--;
         end else begin
            grantQ.push_back(curAr);
         end
      end
      if (expAPush) begin
         mIssued++;
         mNextId = (mNextId + 1) % 256;
         mHeld++;
      end
      if (mFreePend) begin
         mFreeRcvd++;
         if (!curFrValid || curFr.fail) begin
            if (mFreeFail < 65535) mFreeFail++;
         end
      end
      mAllocPend = expAPop;
      mFreePend  = expFPop;
      if (mDone) begin
         mDone = 0;
      end else if (endNow) begin
         mRunning = 0;
         mDone = 1;
      end else if (startIn && !mRunning) begin
         mN = n; mPc = pc;
         mIssued = 0; mAllocRcvd = 0; mFreePushed = 0; mFreeRcvd = 0;
         mHeld = 0; mNextId = 0; mAllocFail = 0; mFreeFail = 0;
         grantQ.delete();
         if (n == 0) mDone = 1;
         else mRunning = 1;
      end
   endtask

   // Idle cycles until the DUT pulses done, or a bounded budget runs out
   task automatic waitDone(input int budget, input string tag);
      int startDone = doneCount;
      for (int i = 0; i < budget && doneCount == startDone; i++) applyStimulus(0, 0, 0);
      if (doneCount == startDone) checkOutput({tag, "_done_timeout"}, 0, 1);
      repeat (2) applyStimulus(0, 0, 0);
   endtask

   // Every output at its reset value
   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_alloc_req_push"}, alloc_req_push, 0);
      checkOutput({tag, "_alloc_req_id"}, alloc_req_id, 0);
      checkOutput({tag, "_alloc_req_page_count"}, alloc_req_page_count, 0);
      checkOutput({tag, "_free_req_push"}, free_req_push, 0);
      checkOutput({tag, "_free_req_id"}, free_req_id, 0);
      checkOutput({tag, "_free_req_page_idx"}, free_req_page_idx, 0);
      checkOutput({tag, "_free_req_page_count"}, free_req_page_count, 0);
      checkOutput({tag, "_alloc_rsp_pop"}, alloc_rsp_pop, 0);
      checkOutput({tag, "_free_rsp_pop"}, free_rsp_pop, 0);
      checkOutput({tag, "_alloc_fail_cnt"}, alloc_fail_cnt, 0);
      checkOutput({tag, "_free_fail_cnt"}, free_fail_cnt, 0);
   endtask

   // Safety net so the run always ends even if the DUT wedges
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios; hand-computed literals pin the model alongside the per-cycle checks
   initial begin
      int base;
      passCount = 0; checkCount = 0; doneCount = 0;
      rst_n = 1'b0; start = 1'b0; cfg_op_count = '0; cfg_page_count = '0;
      alloc_req_fifo_full = 1'b0; free_req_fifo_full = 1'b0;
      alloc_rsp_fifo_empty = 1'b1; free_rsp_fifo_empty = 1'b1;
      alloc_rsp_id = '0; alloc_rsp_page_idx = '0; alloc_rsp_fail = 1'b0; alloc_rsp_fail_reason = '0;
      free_rsp_id = '0; free_rsp_fail = 1'b0; free_rsp_fail_reason = '0;
      resetModel();
      clearEnv();
      repeat (2) @(negedge clk);
      #1;
      checkResetValues("reset");
      rst_n = 1'b1;

      $display("[TB] N=0 run");
      applyStimulus(1, 0, 2);
      repeat (4) applyStimulus(0, 0, 0);
      checkOutput("n0_done_pulses", doneCount, 1);
      checkOutput("n0_pushes", allocIdLog.size() + freeLog.size(), 0);

      $display("[TB] N=4 ideal MMU");
      allocIdLog.delete(); freeLog.delete(); clearEnv();
      applyStimulus(1, 4, 1);
      waitDone(100, "n4");
      checkOutput("n4_alloc_count", allocIdLog.size(), 4);
      checkOutput("n4_free_count", freeLog.size(), 4);
      for (int i = 0; i < 4 && i < allocIdLog.size(); i++) checkOutput("n4_alloc_id", allocIdLog[i], i);
      for (int i = 0; i < 4 && i < freeLog.size(); i++) begin
         checkOutput("n4_free_id", freeLog[i].id, i);
         checkOutput("n4_free_idx", freeLog[i].idx, i * 8);
      end
      checkOutput("n4_alloc_fail_cnt", alloc_fail_cnt, 0);
      checkOutput("n4_free_fail_cnt", free_fail_cnt, 0);

      $display("[TB] N=40 with stalled alloc responses");
      allocIdLog.delete(); freeLog.delete(); clearEnv();
      stallAllocRsp = 1;
      applyStimulus(1, 40, 2);
      repeat (30) applyStimulus(0, 0, 0);
      checkOutput("n40_pushes_while_stalled", allocIdLog.size(), 16);
      stallAllocRsp = 0;
      waitDone(400, "n40");
      checkOutput("n40_alloc_count", allocIdLog.size(), 40);
      checkOutput("n40_free_count", freeLog.size(), 40);
      checkOutput("n40_last_id", (allocIdLog.size() == 40) ? allocIdLog[39] : -1, 39);

      $display("[TB] N=3 with second alloc response failing");
      allocIdLog.delete(); freeLog.delete(); clearEnv();
      failAt = 1;
      applyStimulus(1, 3, 3);
      waitDone(100, "n3");
      checkOutput("n3_alloc_fail_cnt", alloc_fail_cnt, 1);
      checkOutput("n3_free_count", freeLog.size(), 2);
      if (freeLog.size() == 2) begin
         checkOutput("n3_free0_id", freeLog[0].id, 0);
         checkOutput("n3_free1_id", freeLog[1].id, 2);
         checkOutput("n3_free1_idx", freeLog[1].idx, 8);
      end

      $display("[TB] N=12 with alloc request FIFO full for 10 cycles");
      allocIdLog.delete(); freeLog.delete(); clearEnv();
      applyStimulus(1, 12, 4);
      repeat (3) applyStimulus(0, 0, 0);
      forceAllocFull = 1;
      base = allocIdLog.size();
      repeat (10) applyStimulus(0, 0, 0);
      checkOutput("full_pushes_while_full", allocIdLog.size() - base, 0);
      forceAllocFull = 0;
      waitDone(200, "full");
      checkOutput("full_alloc_count", allocIdLog.size(), 12);
      for (int i = 0; i < allocIdLog.size(); i++) checkOutput("full_id_contiguous", allocIdLog[i], i);

      $display("[TB] reset with 5 pages held, then N=2");
      allocIdLog.delete(); freeLog.delete(); clearEnv();
      stallAllocRsp = 1;
      applyStimulus(1, 8, 5);
      for (int i = 0; i < 20 && allocIdLog.size() < 5; i++) applyStimulus(0, 0, 0);
      forceAllocFull = 1;
      repeat (2) applyStimulus(0, 0, 0);
      checkOutput("rst_held_before_reset", allocIdLog.size(), 5);
      rst_n = 1'b0;
      #1;
      checkResetValues("midrun_reset");
      resetModel();
      clearEnv();
      @(negedge clk);
      #1 rst_n = 1'b1;
      allocIdLog.delete(); freeLog.delete();
      applyStimulus(1, 2, 1);
      waitDone(100, "after_reset");
      checkOutput("after_reset_alloc_count", allocIdLog.size(), 2);
      checkOutput("after_reset_free_count", freeLog.size(), 2);
      if (allocIdLog.size() == 2) begin
         checkOutput("after_reset_id0", allocIdLog[0], 0);
         checkOutput("after_reset_id1", allocIdLog[1], 1);
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
